// File: rtl/dcache_write_buffer_pkg.sv
// Shared types and helpers for the data-cache store buffer: size codes,
// drain FSM states and byte-count / granule arithmetic.
package dcache_write_buffer_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } drain_state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    logic [3:0] n;
    case (size)
      SZ_BYTE:  n = 4'd1;
      SZ_HALF:  n = 4'd2;
      SZ_WORD:  n = 4'd4;
      SZ_DWORD: n = 4'd8;
      default:  n = 4'd1;
    endcase
    return n;
  endfunction

  // Granule of the last byte touched; wraps to 0 past the top of memory.
  function automatic logic [28:0] end_granule(input logic [31:0] addr, input logic [1:0] size);
    logic [3:0] reach;
    reach = {1'b0, addr[2:0]} + size_bytes(size);
    return addr[31:3] + {28'd0, (reach > 4'd8)};
  endfunction

endpackage

// File: rtl/dcache_write_buffer_if.sv
// Writeback-store, cache-write and load-conflict signals of the store buffer.
// The buffer sits on the slave modport; the pipeline/cache side uses master.
interface dcache_write_buffer_if;
  logic        WB_wr_v;
  logic [31:0] WB_wr_addr;
  logic [63:0] WB_wr_data;
  logic [1:0]  WB_wr_size;
  logic        write_ready;
  logic        DC_wr_req;
  logic [31:0] DC_wr_addr;
  logic [63:0] DC_wr_data;
  logic [7:0]  DC_wr_mask;
  logic        DC_wr_ack;
  logic [31:0] LD_addr;
  logic [1:0]  LD_size;
  logic        ld_conflict;
  logic        buffer_empty;

  modport slave (
    input  WB_wr_v, WB_wr_addr, WB_wr_data, WB_wr_size, DC_wr_ack, LD_addr, LD_size,
    output write_ready, DC_wr_req, DC_wr_addr, DC_wr_data, DC_wr_mask, ld_conflict, buffer_empty
  );

  modport master (
    output WB_wr_v, WB_wr_addr, WB_wr_data, WB_wr_size, DC_wr_ack, LD_addr, LD_size,
    input  write_ready, DC_wr_req, DC_wr_addr, DC_wr_data, DC_wr_mask, ld_conflict, buffer_empty
  );
endinterface

// File: rtl/dcache_wb_entry_expand.sv
// Expands one store entry into a 16-byte window (two banks): byte enables,
// shifted data, bank-split flag and the first/last 8-byte granules.
module dcache_wb_entry_expand
  import dcache_write_buffer_pkg::*;
(
  input  logic [31:0]  addr_i,
  input  logic [63:0]  data_i,
  input  logic [1:0]   size_i,
  output logic [15:0]  mask16_o,
  output logic [127:0] data128_o,
  output logic         split_o,
  output logic [28:0]  start_granule_o,
  output logic [28:0]  end_granule_o
);
  logic [3:0]  nbytes_s;
  logic [15:0] ones_s;

  assign nbytes_s        = size_bytes(size_i);
  assign ones_s          = (16'd1 << nbytes_s) - 16'd1;
  assign mask16_o        = ones_s << addr_i[2:0];
  assign data128_o       = {64'd0, data_i} << {addr_i[2:0], 3'b000};
  assign split_o         = |mask16_o[15:8];
  assign start_granule_o = addr_i[31:3];
  assign end_granule_o   = end_granule(addr_i, size_i);

endmodule

// File: rtl/dcache_write_buffer.sv
// In-order store buffer between writeback and the data-cache write port,
// with a conservative granule-level conflict check for younger loads.
module dcache_write_buffer
  import dcache_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic                  CLK,
  input logic                  CLR,
  dcache_write_buffer_if.slave bus
);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [31:0]      addr_q [DEPTH];
  logic [63:0]      data_q [DEPTH];
  logic [1:0]       size_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W:0]   count_q;
  drain_state_e     state_q;
  drain_state_e     state_d;

  logic [15:0]      mask16_s  [DEPTH];
  logic [127:0]     data128_s [DEPTH];
  logic [DEPTH-1:0] split_s;
  logic [28:0]      start_g_s [DEPTH];
  logic [28:0]      end_g_s   [DEPTH];

  logic [31:0]  bank_addr_s;
  logic [15:0]  head_mask_s;
  logic [127:0] head_data_s;
  logic         head_split_s;
  logic [28:0]  ld_start_s;
  logic [28:0]  ld_end_s;
  logic         push_s;
  logic         pop_s;
  logic         req_s;
  logic [31:0]  wr_addr_s;
  logic [63:0]  wr_data_s;
  logic [7:0]   wr_mask_s;
  logic         conflict_s;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    dcache_wb_entry_expand u_expand (
      .addr_i          (addr_q[gi]),
      .data_i          (data_q[gi]),
      .size_i          (size_q[gi]),
      .mask16_o        (mask16_s[gi]),
      .data128_o       (data128_s[gi]),
      .split_o         (split_s[gi]),
      .start_granule_o (start_g_s[gi]),
      .end_granule_o   (end_g_s[gi])
    );
  end

  assign bank_addr_s  = {addr_q[head_q][31:3], 3'b000};
  assign head_mask_s  = mask16_s[head_q];
  assign head_data_s  = data128_s[head_q];
  assign head_split_s = split_s[head_q];
  assign ld_start_s   = bus.LD_addr[31:3];
  assign ld_end_s     = end_granule(bus.LD_addr, bus.LD_size);
  assign push_s       = bus.WB_wr_v & bus.write_ready;

  assign bus.write_ready  = (count_q != CNT_FULL);
  assign bus.buffer_empty = (count_q == '0) && (state_q == ST_IDLE);
  assign bus.DC_wr_req    = req_s;
  assign bus.DC_wr_addr   = wr_addr_s;
  assign bus.DC_wr_data   = wr_data_s;
  assign bus.DC_wr_mask   = wr_mask_s;
  assign bus.ld_conflict  = conflict_s;

  // Drain FSM next state and bank-write outputs; (count - 1) != 0 decides LO vs IDLE after a pop
  always_comb begin
    state_d   = state_q;
    pop_s     = 1'b0;
    req_s     = 1'b0;
    wr_addr_s = 32'd0;
    wr_data_s = 64'd0;
    wr_mask_s = 8'd0;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          state_d = ST_LO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LO: begin
        req_s     = 1'b1;
        wr_addr_s = bank_addr_s;
        wr_mask_s = head_mask_s[7:0];
        wr_data_s = head_data_s[63:0];
        if (bus.DC_wr_ack && head_split_s) begin
          state_d = ST_HI;
        end else if (bus.DC_wr_ack) begin
          pop_s   = 1'b1;
          state_d = (count_q != CNT_ONE) ? ST_LO : ST_IDLE;
        end else begin
          state_d = ST_LO;
        end
      end
      ST_HI: begin
        req_s     = 1'b1;
        wr_addr_s = bank_addr_s + 32'd8;
        wr_mask_s = head_mask_s[15:8];
        wr_data_s = head_data_s[127:64];
        if (bus.DC_wr_ack) begin
          pop_s   = 1'b1;
          state_d = (count_q != CNT_ONE) ? ST_LO : ST_IDLE;
        end else begin
          state_d = ST_HI;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Load conflict: any load granule matching any granule of a still-valid entry
  always_comb begin
    conflict_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && ((start_g_s[i] == ld_start_s) || (start_g_s[i] == ld_end_s) ||
                         (end_g_s[i] == ld_start_s)   || (end_g_s[i] == ld_end_s))) begin
        conflict_s = 1'b1;
      end else begin
        conflict_s = conflict_s;
      end
    end
  end

  // Entry storage, pointers, occupancy and drain state
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= ST_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= 32'd0;
        data_q[i] <= 64'd0;
        size_q[i] <= 2'd0;
      end
    end else begin
      state_q <= state_d;
      if (push_s) begin
        addr_q[tail_q]  <= bus.WB_wr_addr;
        data_q[tail_q]  <= bus.WB_wr_data;
        size_q[tail_q]  <= bus.WB_wr_size;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_ONE;
      end
      if (pop_s) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Bench for dcache_write_buffer: queue-of-stores reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_dcache_write_buffer;
  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic CLR;

  dcache_write_buffer_if bus();

  dcache_write_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] a;
    logic [63:0] d;
    logic [1:0]  s;
  } st_t;

  st_t mq[$];
  bit  m_active;
  bit  m_half;
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return 1 << s;
  endfunction

  function automatic bit spans(input st_t e);
    return (int'(e.a[2:0]) + nbytes(e.s)) > 8;
  endfunction

  // Bank write k (0/1) of a store: byte b of the bank is store byte (8k + b - offset)
  task automatic exp_bank(input st_t e, input bit half, output logic [31:0] ba,
                          output logic [7:0] m, output logic [63:0] d);
    int j;
    ba = {e.a[31:3], 3'b000} + (half ? 32'd8 : 32'd0);
    m  = 8'd0;
    d  = 64'd0;
    for (int b = 0; b < 8; b++) begin
      j = (half ? 8 : 0) + b - int'(e.a[2:0]);
      if (j >= 0 && j < 8) begin
        d[8*b +: 8] = e.d[8*j +: 8];
        if (j < nbytes(e.s)) m[b] = 1'b1;
      end
    end
  endtask

  function automatic bit model_conflict(input logic [31:0] la, input logic [1:0] ls);
    logic [31:0] l0, l1, e0, e1;
    bit hit;
    hit = 1'b0;
    l0  = la >> 3;
    l1  = (la + 32'(nbytes(ls)) - 32'd1) >> 3;
    foreach (mq[i]) begin
      e0 = mq[i].a >> 3;
      e1 = (mq[i].a + 32'(nbytes(mq[i].s)) - 32'd1) >> 3;
      if (l0 == e0 || l0 == e1 || l1 == e0 || l1 == e1) hit = 1'b1;
    end
    return hit;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_active = 1'b0;
    m_half   = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_update();
    int sz;
    bit push;
    if (CLR) begin
      model_reset();
    end else begin
      sz   = mq.size();
      push = bus.WB_wr_v && (sz < DEPTH);
      if (m_active) begin
        if (bus.DC_wr_ack) begin
          if (!m_half && spans(mq[0])) begin
            m_half = 1'b1;
          end else begin
            mq.delete(0);
            m_half   = 1'b0;
            m_active = (sz - 1) != 0;
          end
        end
      end else begin
        m_active = (sz != 0);
      end
      if (push) mq.push_back('{bus.WB_wr_addr, bus.WB_wr_data, bus.WB_wr_size});
    end
  endtask

  task automatic model_check();
    logic [31:0] ba;
    logic [7:0]  m;
    logic [63:0] d;
    if (m_active) begin
      exp_bank(mq[0], m_half, ba, m, d);
    end else begin
      ba = 32'd0; m = 8'd0; d = 64'd0;
    end
    chk("write_ready",  64'(bus.write_ready),  64'(mq.size() != DEPTH));
    chk("buffer_empty", 64'(bus.buffer_empty), 64'(mq.size() == 0 && !m_active));
    chk("DC_wr_req",    64'(bus.DC_wr_req),    64'(m_active));
    chk("DC_wr_addr",   64'(bus.DC_wr_addr),   64'(ba));
    chk("DC_wr_mask",   64'(bus.DC_wr_mask),   64'(m));
    chk("DC_wr_data",   bus.DC_wr_data,        d);
    chk("ld_conflict",  64'(bus.ld_conflict),  64'(model_conflict(bus.LD_addr, bus.LD_size)));
  endtask

  task automatic tick_check();
    @(negedge CLK);
    model_check();
  endtask

  task automatic tick_adv();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic step();
    tick_check();
    tick_adv();
  endtask

  task automatic push_store(input logic [31:0] a, input logic [63:0] d, input logic [1:0] s);
    bus.WB_wr_v    = 1'b1;
    bus.WB_wr_addr = a;
    bus.WB_wr_data = d;
    bus.WB_wr_size = s;
    step();
    bus.WB_wr_v = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    bus.WB_wr_v   = 1'b0;
    bus.DC_wr_ack = 1'b1;
    while ((mq.size() != 0 || m_active) && k < budget) begin
      step();
      k++;
    end
    bus.DC_wr_ack = 1'b0;
    tick_check();
    chk("drain_done", 64'(bus.buffer_empty), 64'd1);
    tick_adv();
  endtask

  initial begin
    model_reset();
    CLR            = 1'b1;
    bus.WB_wr_v    = 1'b0;
    bus.WB_wr_addr = 32'd0;
    bus.WB_wr_data = 64'd0;
    bus.WB_wr_size = 2'd0;
    bus.DC_wr_ack  = 1'b0;
    bus.LD_addr    = 32'h0000_9000;
    bus.LD_size    = 2'd0;

    // Reset state
    tick_check();
    chk("rst_write_ready",  64'(bus.write_ready),  64'd1);
    chk("rst_buffer_empty", 64'(bus.buffer_empty), 64'd1);
    chk("rst_req",          64'(bus.DC_wr_req),    64'd0);
    tick_adv();
    CLR = 1'b0;

    // Aligned word store, ack after two cycles
    push_store(32'h0000_1000, 64'h0000_0000_DEAD_BEEF, 2'b10);
    step();
    tick_check();
    chk("al_req",  64'(bus.DC_wr_req),  64'd1);
    chk("al_addr", 64'(bus.DC_wr_addr), 64'h1000);
    chk("al_mask", 64'(bus.DC_wr_mask), 64'h0F);
    chk("al_data", bus.DC_wr_data,      64'h0000_0000_DEAD_BEEF);
    tick_adv();
    bus.DC_wr_ack = 1'b1;
    tick_check();
    chk("al_req_held", 64'(bus.DC_wr_req), 64'd1);
    tick_adv();
    bus.DC_wr_ack = 1'b0;
    tick_check();
    chk("al_empty", 64'(bus.buffer_empty), 64'd1);
    chk("al_req_done", 64'(bus.DC_wr_req), 64'd0);
    tick_adv();

    // Store split across banks 0x1000 / 0x1008
    push_store(32'h0000_1006, 64'h0000_0000_1122_3344, 2'b10);
    step();
    bus.DC_wr_ack = 1'b1;
    tick_check();
    chk("sp_lo_addr", 64'(bus.DC_wr_addr), 64'h1000);
    chk("sp_lo_mask", 64'(bus.DC_wr_mask), 64'hC0);
    chk("sp_lo_data", bus.DC_wr_data,      64'h3344_0000_0000_0000);
    tick_adv();
    tick_check();
    chk("sp_hi_addr", 64'(bus.DC_wr_addr), 64'h1008);
    chk("sp_hi_mask", 64'(bus.DC_wr_mask), 64'h03);
    chk("sp_hi_data", bus.DC_wr_data,      64'h0000_0000_0000_1122);
    tick_adv();
    bus.DC_wr_ack = 1'b0;
    step();

    // Fill to DEPTH with ack held low, a 5th store waits
    for (int i = 0; i < 4; i++) push_store(32'h5000 + 32'(16 * i), {$urandom, $urandom}, 2'b11);
    bus.WB_wr_v    = 1'b1;
    bus.WB_wr_addr = 32'h0000_5100;
    bus.WB_wr_data = 64'h0102_0304_0506_0708;
    bus.WB_wr_size = 2'b11;
    tick_check();
    chk("full_not_ready", 64'(bus.write_ready), 64'd0);
    tick_adv();
    bus.DC_wr_ack = 1'b1;
    tick_check();
    chk("full_still_not_ready", 64'(bus.write_ready), 64'd0);
    tick_adv();
    tick_check();
    chk("ready_after_pop", 64'(bus.write_ready), 64'd1);
    tick_adv();
    bus.WB_wr_v = 1'b0;
    drain(40);

    // Push and pop on the same edge with two entries held
    bus.DC_wr_ack = 1'b0;
    push_store(32'h0000_6000, 64'hAAAA_0000_0000_0001, 2'b11);
    push_store(32'h0000_6010, 64'hAAAA_0000_0000_0002, 2'b11);
    bus.WB_wr_v    = 1'b1;
    bus.WB_wr_addr = 32'h0000_6020;
    bus.WB_wr_data = 64'hAAAA_0000_0000_0003;
    bus.DC_wr_ack  = 1'b1;
    step();
    bus.WB_wr_v   = 1'b0;
    bus.DC_wr_ack = 1'b0;
    tick_check();
    chk("pp_next_addr", 64'(bus.DC_wr_addr), 64'h6010);
    tick_adv();
    drain(40);

    // Load conflict against a pending word at 0x2004
    push_store(32'h0000_2004, 64'h0000_0000_CAFE_F00D, 2'b10);
    bus.LD_addr = 32'h0000_2000;
    bus.LD_size = 2'b00;
    tick_check();
    chk("cf_hit", 64'(bus.ld_conflict), 64'd1);
    tick_adv();
    bus.LD_addr = 32'h0000_2008;
    tick_check();
    chk("cf_miss", 64'(bus.ld_conflict), 64'd0);
    tick_adv();
    drain(20);
    bus.LD_addr = 32'h0000_2000;
    tick_check();
    chk("cf_after_drain", 64'(bus.ld_conflict), 64'd0);
    tick_adv();

    // Reset while in the high half with three entries pending
    push_store(32'h0000_3006, 64'h0000_0000_5566_7788, 2'b10);
    push_store(32'h0000_3010, 64'h1111_2222_3333_4444, 2'b11);
    push_store(32'h0000_3020, 64'h5555_6666_7777_8888, 2'b11);
    bus.DC_wr_ack = 1'b1;
    step();
    bus.DC_wr_ack = 1'b0;
    tick_check();
    chk("hi_before_rst", 64'(bus.DC_wr_addr), 64'h3008);
    tick_adv();
    CLR = 1'b1;
    #1;
    chk("rst_async_req", 64'(bus.DC_wr_req), 64'd0);
    model_reset();
    step();
    CLR           = 1'b0;
    bus.DC_wr_ack = 1'b1;
    tick_check();
    chk("post_rst_ready", 64'(bus.write_ready),  64'd1);
    chk("post_rst_empty", 64'(bus.buffer_empty), 64'd1);
    tick_adv();
    repeat (4) step();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      bus.WB_wr_v = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) bus.WB_wr_addr = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      else                            bus.WB_wr_addr = 32'h0000_4000 + 32'($urandom_range(0, 63));
      bus.WB_wr_data = {$urandom, $urandom};
      bus.WB_wr_size = 2'($urandom_range(0, 3));
      bus.DC_wr_ack  = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0:       bus.LD_addr = 32'($urandom_range(0, 15));
        1:       bus.LD_addr = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
        default: bus.LD_addr = 32'h0000_4000 + 32'($urandom_range(0, 71));
      endcase
      bus.LD_size = 2'($urandom_range(0, 3));
      step();
    end
    drain(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
